// File: rtl/regfile_2r2w.sv
// regfile_2r2w: parameterised 2-read / 2-write register file for the 8-bit CPU datapath.
// Reads are registered and see same-edge writes (write-first). Port 1 wins when both
// write ports target the same entry. After reset or a clr_req pulse, a clear sequencer
// zeroes the entries one per cycle. The file is not usable while that walk runs.
// Optional build macro: R0_ZERO_EN hardwires entry 0 to zero. Writes to address 0 are
// dropped, and reads of address 0 return 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing entry r_clr_cnt each cycle; ready=0, writes/reads off
// ST_READY | normal operation; clr_req restarts the clear walk at entry 0

module regfile_2r2w #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   input  logic              w_en1,
   input  logic [ADDR_W-1:0] addr_w1,
   input  logic [DATA_W-1:0] buf_w1,
   input  logic              w_en2,
   input  logic [ADDR_W-1:0] addr_w2,
   input  logic [DATA_W-1:0] buf_w2,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] addr_r1,
   input  logic [ADDR_W-1:0] addr_r2,
   output logic [DATA_W-1:0] buf_r1,
   output logic [DATA_W-1:0] buf_r2,
   output logic              rd_valid,
   output logic              ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic                r_ready;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_buf_r1;
   logic [DATA_W-1:0]   r_buf_r2;
   logic                r_rd_valid;

   logic                w_wr_ok;
   logic                w_collide;
   logic                w_a1_ok;
   logic                w_a2_ok;
   logic                w_acc1;
   logic                w_acc2;
   logic [DATA_W-1:0]   w_rd1;
   logic [DATA_W-1:0]   w_rd2;

   // A clear request in READY takes priority over any write on the same edge.
   assign w_wr_ok   = r_ready & ~clr_req;
   assign w_collide = w_en1 & w_en2 & (addr_w1 == addr_w2);

`ifdef R0_ZERO_EN
   assign w_a1_ok = (addr_w1 != '0);
   assign w_a2_ok = (addr_w2 != '0);
`else
   assign w_a1_ok = 1'b1;
   assign w_a2_ok = 1'b1;
`endif

   // A port-2 write that collides with port 1 is dropped even if port 1's own
   // write is dropped (e.g. address 0 with R0 hardwired).
   assign w_acc1 = w_wr_ok & w_en1 & w_a1_ok;
   assign w_acc2 = w_wr_ok & w_en2 & w_a2_ok & ~w_collide;

   // Read port 1 data with write-first bypass; port 1 bypass overrides port 2.
   always_comb begin
      w_rd1 = r_mem[addr_r1];
      if (w_acc2 && (addr_w2 == addr_r1)) w_rd1 = buf_w2;
      if (w_acc1 && (addr_w1 == addr_r1)) w_rd1 = buf_w1;
`ifdef R0_ZERO_EN
      if (addr_r1 == '0) w_rd1 = '0;
`endif
   end

   // Read port 2 data with write-first bypass; port 1 bypass overrides port 2.
   always_comb begin
      w_rd2 = r_mem[addr_r2];
      if (w_acc2 && (addr_w2 == addr_r2)) w_rd2 = buf_w2;
      if (w_acc1 && (addr_w1 == addr_r2)) w_rd2 = buf_w1;
`ifdef R0_ZERO_EN
      if (addr_r2 == '0) w_rd2 = '0;
`endif
   end

   // Clear sequencer FSM. ready is registered and rises with the move to ST_READY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_clr_cnt == LAST_IDX) begin
                  r_state <= ST_READY;
                  r_ready <= 1'b1;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            ST_READY: begin
               if (clr_req) begin
                  r_state   <= ST_CLEAR;
                  r_clr_cnt <= '0;
                  r_ready   <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_CLEAR;
               r_clr_cnt <= '0;
               r_ready   <= 1'b0;
            end
         endcase
      end
   end

   // Storage. There is no reset here; the clear walk zeroes every entry.
   // A collision never enables both ports, so the two writes below never alias.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_clr_cnt] <= '0;
      end else begin
         if (w_acc1) r_mem[addr_w1] <= buf_w1;
         if (w_acc2) r_mem[addr_w2] <= buf_w2;
      end
   end

   // Registered read ports. Outputs are zero whenever no read was performed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf_r1   <= '0;
         r_buf_r2   <= '0;
         r_rd_valid <= 1'b0;
      end else if (r_en && r_ready) begin
         r_buf_r1   <= w_rd1;
         r_buf_r2   <= w_rd2;
         r_rd_valid <= 1'b1;
      end else begin
         r_buf_r1   <= '0;
         r_buf_r2   <= '0;
         r_rd_valid <= 1'b0;
      end
   end

   assign buf_r1   = r_buf_r1;
   assign buf_r2   = r_buf_r2;
   assign rd_valid = r_rd_valid;
   assign ready    = r_ready;

endmodule

// File: tb/tb_regfile_2r2w.sv
// Bench for regfile_2r2w: directed and randomized cycles against a reference model.
// The model keeps the register contents as an array. Writes are applied port 2 first
// and then port 1, so port 1 wins. Reads then index the updated array.

module tb_regfile_2r2w;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr_req = 1'b0;
   logic       w_en1 = 1'b0, w_en2 = 1'b0, r_en = 1'b0;
   logic [2:0] addr_w1 = '0, addr_w2 = '0, addr_r1 = '0, addr_r2 = '0;
   logic [7:0] buf_w1 = '0, buf_w2 = '0;
   logic [7:0] buf_r1, buf_r2;
   logic       rd_valid, ready;

   typedef struct {
      logic       rdy;
      logic       v;
      logic [7:0] d1;
      logic [7:0] d2;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_mem [8];
   bit         m_ready = 1'b0;
   int         m_cnt = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   regfile_2r2w #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .w_en1(w_en1), .addr_w1(addr_w1), .buf_w1(buf_w1),
      .w_en2(w_en2), .addr_w2(addr_w2), .buf_w2(buf_w2),
      .r_en(r_en), .addr_r1(addr_r1), .addr_r2(addr_r2),
      .buf_r1(buf_r1), .buf_r2(buf_r2), .rd_valid(rd_valid), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit addr_ok(input logic [2:0] a);
`ifdef R0_ZERO_EN
      return a != 3'd0;
`else
      return 1'b1;
`endif
   endfunction

   // One clock cycle: drive at negedge, advance the model, queue the expected output.
   task automatic drv(input bit rst, input bit clr,
                      input bit we1, input logic [2:0] aw1, input logic [7:0] bw1,
                      input bit we2, input logic [2:0] aw2, input logic [7:0] bw2,
                      input bit re, input logic [2:0] ar1, input logic [2:0] ar2);
      exp_t       e;
      logic [7:0] nm [8];
      @(negedge clk);
      rst_n = ~rst; clr_req = clr;
      w_en1 = we1; addr_w1 = aw1; buf_w1 = bw1;
      w_en2 = we2; addr_w2 = aw2; buf_w2 = bw2;
      r_en = re; addr_r1 = ar1; addr_r2 = ar2;
      e = '{rdy: 1'b0, v: 1'b0, d1: 8'h00, d2: 8'h00};
      if (rst) begin
         m_ready = 1'b0;
         m_cnt   = 0;
      end else if (!m_ready) begin
         m_mem[m_cnt] = 8'h00;
         if (m_cnt == 7) m_ready = 1'b1;
         else m_cnt++;
         e.rdy = m_ready;
      end else begin
         nm = m_mem;
         if (!clr) begin
            if (we2 && addr_ok(aw2)) nm[aw2] = bw2;
            if (we1 && addr_ok(aw1)) nm[aw1] = bw1;
         end
         if (re) begin
            e.v  = 1'b1;
            e.d1 = nm[ar1];
            e.d2 = nm[ar2];
         end
         m_mem = nm;
         if (clr) begin
            m_ready = 1'b0;
            m_cnt   = 0;
         end
         e.rdy = m_ready;
      end
      q.push_back(e);
   endtask

   task automatic nop(input int n);
      repeat (n) drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1,
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
   endtask

   // Monitor: pops one expectation per clock edge, samples 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready", {7'd0, ready}, {7'd0, e.rdy});
            chk("rd_valid", {7'd0, rd_valid}, {7'd0, e.v});
            chk("buf_r1", buf_r1, e.d1);
            chk("buf_r2", buf_r2, e.d2);
         end
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;

      // Reset, then the clear walk; afterwards read every entry.
      drv(1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd0, 3'd0);
      drv(1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd0, 3'd0);
      nop(9);
      for (int i = 0; i < 4; i++)
         drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'(2 * i), 3'(2 * i + 1));

      // Two independent writes, then read them back.
      drv(0, 0, 1, 3'd3, 8'hA5, 1, 3'd5, 8'h3C, 0, 3'd0, 3'd0);
      drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd3, 3'd5);

      // Collision on address 2 with a same-cycle read of 2, then read it again.
      drv(0, 0, 1, 3'd2, 8'h11, 1, 3'd2, 8'h22, 1, 3'd2, 3'd5);
      drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd2, 3'd3);

      // Port-2 bypass on r2 while port 1 writes elsewhere.
      drv(0, 0, 1, 3'd6, 8'h66, 1, 3'd7, 8'h99, 1, 3'd6, 3'd7);

      // r_en low with stored data present.
      drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd3, 3'd5);

      // Clear request with a concurrent write to 4, then read 4 back.
      drv(0, 0, 1, 3'd4, 8'h44, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);
      drv(0, 1, 1, 3'd4, 8'h77, 0, 3'd0, 8'h00, 1, 3'd4, 3'd3);
      nop(9);
      drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd4, 3'd3);

      // Reset pulse in the middle of a clear walk.
      drv(0, 0, 1, 3'd1, 8'h5A, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);
      drv(0, 1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);
      nop(3);
      drv(1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd1, 3'd1);
      nop(10);

      // Address 0: ordinary register, or hardwired zero when R0_ZERO_EN is defined.
      drv(0, 0, 1, 3'd0, 8'hFF, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);
      drv(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd0, 3'd1);
      drv(0, 0, 1, 3'd0, 8'hEE, 1, 3'd0, 8'hDD, 1, 3'd0, 3'd0);
      drv(0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 8'hCC, 1, 3'd0, 3'd1);

      // Randomized traffic with occasional clear requests and resets.
      for (int i = 0; i < 500; i++) begin
         drv(($urandom_range(0, 249) == 0), ($urandom_range(0, 39) == 0),
             $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      nop(2);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
